// File: rtl/trng_link_pkg.sv
// Shared definitions for the TRNG link framing path.
//   state_e          : frame scheduler FSM encoding
//   HEADER_BYTE_DEF  : default first byte of every frame
//   BYTE_W / OVF_W   : data byte width and overflow counter width
//   PCNT_W           : payload counter width
//   sat_inc()        : saturating increment for the overflow counter
package trng_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_SEND_PAY,
    ST_SEND_TRL,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int         BYTE_W          = 8;
  localparam int         OVF_W           = 8;
  localparam int         PCNT_W          = 16;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == '1) ? v : v + OVF_W'(1);
  endfunction

endpackage

// File: rtl/trng_frame_scheduler_if.sv
// Byte-stream link bundle around the frame scheduler.
//   rnd_valid/rnd_byte : single-cycle strobe + byte from the LSB packer
//   is_transmitting    : UART sender busy
//   tx_byte/transmit   : byte + single-cycle send strobe to the UART sender
// master = scheduler side, slave = packer/UART side.
interface trng_frame_scheduler_if;
  import trng_link_pkg::*;

  logic              rnd_valid;
  logic [BYTE_W-1:0] rnd_byte;
  logic              is_transmitting;
  logic [BYTE_W-1:0] tx_byte;
  logic              transmit;

  modport master (
    input  rnd_valid, rnd_byte, is_transmitting,
    output tx_byte, transmit
  );

  modport slave (
    output rnd_valid, rnd_byte, is_transmitting,
    input  tx_byte, transmit
  );

endinterface

// File: rtl/trng_byte_fifo.sv
// Synchronous byte FIFO, no read bypass (a push into an empty FIFO is visible
// from the next cycle). Flush has priority over push/pop.
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : empty the FIFO at the next edge
//   push, wr_data   : write request (accepted when not full, or full with pop)
//   pop, rd_data    : read request, rd_data is the current head
//   full, empty     : status
//   count           : number of stored entries
module trng_byte_fifo
  import trng_link_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       wr_data,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !flush;
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/trng_frame_scheduler.sv
// Frames the TRNG byte stream for the PC link: header, PAYLOAD_LEN buffered
// random bytes, XOR checksum trailer. Random bytes arriving while a frame is
// in flight are queued in a small FIFO; bytes that find it full are dropped
// and counted in ovf_cnt (saturating).
//   clk, rst    : clock, asynchronous active-high reset
//   start       : single-cycle frame request (ignored while busy)
//   link        : packer strobe/byte in, UART tx_byte/transmit/is_transmitting
//   busy        : frame accepted and not yet finished
//   frame_done  : single-cycle pulse at end of frame
//   ovf_cnt     : dropped payload bytes in the current or last frame
module trng_frame_scheduler
  import trng_link_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 64,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  trng_frame_scheduler_if.master link,
  output logic                   busy,
  output logic                   frame_done,
  output logic [OVF_W-1:0]       ovf_cnt
);
  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PCNT_W-1:0] PAY_LEN = PCNT_W'(PAYLOAD_LEN);

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic                gap_first_q, gap_first_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                transmit_q, transmit_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;

  logic                fifo_flush, fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [BYTE_W-1:0]   fifo_rd;
  logic [CNT_W-1:0]    fifo_count;
  logic                can_send;

  trng_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wr_data (link.rnd_byte),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb assert (fifo_count <= CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    gap_first_d  = gap_first_q;
    tx_byte_d    = tx_byte_q;
    transmit_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q;
    csum_d       = csum_q;
    pcnt_d       = pcnt_q;
    fifo_flush   = 1'b0;
    fifo_pop     = 1'b0;
    can_send     = !link.is_transmitting;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SEND_HDR;
          fifo_flush = 1'b1;
          ovf_d      = '0;
          csum_d     = '0;
          pcnt_d     = '0;
          busy_d     = 1'b1;
        end
      end
      ST_SEND_HDR: begin
        if (can_send) begin
          tx_byte_d   = HEADER_BYTE;
          transmit_d  = 1'b1;
          state_d     = ST_GAP;
          ret_d       = ST_SEND_PAY;
          gap_first_d = 1'b1;
        end
      end
      ST_SEND_PAY: begin
        if (can_send && !fifo_empty) begin
          fifo_pop    = 1'b1;
          tx_byte_d   = fifo_rd;
          transmit_d  = 1'b1;
          csum_d      = csum_q ^ fifo_rd;
          pcnt_d      = pcnt_q + PCNT_W'(1);
          state_d     = ST_GAP;
          ret_d       = (pcnt_d == PAY_LEN) ? ST_SEND_TRL : ST_SEND_PAY;
          gap_first_d = 1'b1;
        end
      end
      ST_SEND_TRL: begin
        if (can_send) begin
          tx_byte_d   = csum_q;
          transmit_d  = 1'b1;
          state_d     = ST_GAP;
          ret_d       = ST_DONE;
          gap_first_d = 1'b1;
        end
      end
      ST_GAP: begin
        // The UART only raises is_transmitting after seeing our strobe, so
        // its value in the first gap cycle is stale and must not release us.
        if (gap_first_q)   gap_first_d = 1'b0;
        else if (can_send) state_d     = ret_q;
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Random bytes are only buffered while a frame is live; outside that
    // window they are neither stored nor counted as lost.
    fifo_push = link.rnd_valid && (state_q != ST_IDLE) && (state_q != ST_DONE);
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = sat_inc(ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      gap_first_q  <= 1'b0;
      tx_byte_q    <= '0;
      transmit_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= '0;
      csum_q       <= '0;
      pcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      gap_first_q  <= gap_first_d;
      tx_byte_q    <= tx_byte_d;
      transmit_q   <= transmit_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
      csum_q       <= csum_d;
      pcnt_q       <= pcnt_d;
    end
  end

  assign link.tx_byte  = tx_byte_q;
  assign link.transmit = transmit_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_trng_frame_scheduler.sv
// Directed bench for trng_frame_scheduler (PAYLOAD_LEN=4, FIFO_DEPTH=4).
// A small UART model holds is_transmitting for uart_len cycles per byte (or
// permanently while hold=1); a negedge monitor records every sent byte.
module tb_trng_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, frame_done;
  logic [7:0] ovf_cnt;

  trng_frame_scheduler_if link();

  trng_frame_scheduler #(
    .PAYLOAD_LEN (4),
    .FIFO_DEPTH  (4),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .link       (link),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] got[$];
  int         fd_cnt = 0;
  logic       fd_busy = 1'b1;
  int         uart_len = 10;
  int         uart_cnt = 0;
  logic       hold = 1'b0;

  // Monitor + UART model, both on the inactive edge.
  always @(negedge clk) begin
    if (link.transmit) got.push_back(link.tx_byte);
    if (frame_done) begin
      fd_cnt++;
      fd_busy = busy;
    end
    if (hold) link.is_transmitting = 1'b1;
    else if (link.transmit && uart_len > 0) begin
      uart_cnt = uart_len;
      link.is_transmitting = 1'b1;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      link.is_transmitting = (uart_cnt != 0);
    end else link.is_transmitting = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    link.rnd_valid = 1'b1;
    link.rnd_byte  = b;
    tick();
    link.rnd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (got.size() < n && k < 500) begin
      tick();
      k++;
    end
    chk("tx_wait", 32'(got.size() >= n), 1);
  endtask

  task automatic wait_done();
    int fd0 = fd_cnt;
    int k = 0;
    while (fd_cnt == fd0 && k < 2000) begin
      tick();
      k++;
    end
    chk("frame_done_seen", fd_cnt - fd0, 1);
    chk("busy_at_done", 32'(fd_busy), 0);
  endtask

  // exp holds the six frame bytes, first byte in the top octet.
  task automatic check_frame(input string tag, input logic [47:0] exp);
    logic [7:0] g;
    chk({tag, "_len"}, got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      g = (i < got.size()) ? got[i] : 8'h00;
      chk($sformatf("%s_b%0d", tag, i), 32'(g), 32'(exp[47-8*i -: 8]));
    end
  endtask

  initial begin
    int fd_base;
    link.rnd_valid = 1'b0;
    link.rnd_byte  = 8'h00;

    // Reset values
    #1;
    chk("rst_busy",       32'(busy), 0);
    chk("rst_transmit",   32'(link.transmit), 0);
    chk("rst_tx_byte",    32'(link.tx_byte), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_ovf",        32'(ovf_cnt), 0);
    ticks(2);
    rst = 1'b0;
    tick();

    // Start -> busy next cycle, header first; then async reset mid-cycle
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    wait_tx(1);
    chk("hdr_byte", 32'(got.size() > 0 ? got[0] : 8'h00), 32'h A5);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy",    32'(busy), 0);
    chk("async_rst_tx_byte", 32'(link.tx_byte), 0);
    chk("async_rst_ovf",     32'(ovf_cnt), 0);
    tick();
    rst = 1'b0;

    // Basic frame
    got.delete();
    pulse_start();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_done();
    check_frame("basic", 48'hA5_01_02_03_04_04);
    chk("basic_busy", 32'(busy), 0);
    chk("basic_ovf",  32'(ovf_cnt), 0);

    // Overflow: UART held after header, 6 pushes into a 4-deep FIFO
    got.delete();
    pulse_start();
    wait_tx(1);
    hold = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    chk("ovf_cnt_2", 32'(ovf_cnt), 2);
    hold = 1'b0;
    wait_done();
    check_frame("ovf", 48'hA5_10_11_12_13_00);
    chk("ovf_kept", 32'(ovf_cnt), 2);

    // Full FIFO + pop in the same cycle as rnd_valid
    uart_len = 0;
    got.delete();
    pulse_start();
    wait_tx(1);
    hold = 1'b1;
    push(8'h21); push(8'h42); push(8'h84); push(8'h18);
    hold = 1'b0;
    tick();                 // GAP releases -> SEND_PAY
    link.rnd_valid = 1'b1;  // lands on the pop edge
    link.rnd_byte  = 8'h99;
    tick();
    link.rnd_valid = 1'b0;
    chk("pop_push_transmit", 32'(link.transmit), 1);
    chk("pop_push_byte",     32'(link.tx_byte), 32'h21);
    chk("pop_push_ovf",      32'(ovf_cnt), 0);
    wait_done();
    check_frame("full_pop", 48'hA5_21_42_84_18_FF);
    chk("full_pop_ovf", 32'(ovf_cnt), 0);

    // rnd_valid in IDLE is dropped and not counted
    uart_len = 10;
    got.delete();
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    ticks(5);
    chk("idle_no_tx", got.size(), 0);
    chk("idle_ovf",   32'(ovf_cnt), 0);
    chk("idle_busy",  32'(busy), 0);

    // start during payload is ignored; leftover/idle bytes were flushed
    fd_base = fd_cnt;
    pulse_start();
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    wait_tx(3);
    pulse_start();
    wait_done();
    check_frame("ign_start", 48'hA5_05_06_07_08_0C);
    ticks(40);
    chk("ign_start_fd_cnt", fd_cnt - fd_base, 1);
    chk("ign_start_no_tx",  got.size(), 6);
    chk("ign_start_busy",   32'(busy), 0);

    // Reset after 2 of 4 payload bytes, then a fresh frame
    got.delete();
    pulse_start();
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    wait_tx(3);
    #1 rst = 1'b1;
    #1;
    chk("pay_rst_busy",    32'(busy), 0);
    chk("pay_rst_tx_byte", 32'(link.tx_byte), 0);
    tick();
    rst = 1'b0;
    got.delete();
    pulse_start();
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    wait_done();
    check_frame("after_rst", 48'hA5_41_42_43_44_04);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
